// File: rtl/vram_scanout.sv
`timescale 1ns/1ps
// vram_scanout: VGA raster generator and scan-out reader for the pixel VRAM.
// Walks the 640x480 (parameterised) raster, issues one VRAM read address per
// pixel for the top-left IMG_W x IMG_H image, and converts the returned
// grayscale byte to RGB. Everything outside the image is black.
//
// Ports:
//   clk          pixel clock, one pixel per cycle
//   reset        asynchronous, active-high
//   gpu_address  VRAM read address (registered, BASE_ADDR outside the image)
//   vram_out     VRAM read data, one cycle after gpu_address
//   vga_hsync    active-low horizontal sync
//   vga_vsync    active-low vertical sync
//   vga_blank_n  high in the visible area
//   vga_r/g/b    pixel colour
//   frame_start  one-cycle pulse while outputs show pixel (0,0)
//
// Latency: counter position in cycle t -> address in t+1 -> data in t+2 ->
// all VGA outputs in t+3. Sync/blank/frame flags ride a matching pipeline.
module vram_scanout #(
  parameter int          H_ACTIVE  = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_ACTIVE  = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33,
  parameter int          IMG_W     = 256,
  parameter int          IMG_H     = 256,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] gpu_address,
  input  logic [7:0]  vram_out,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_IMG  = HW'(IMG_W);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_IMG  = VW'(IMG_H);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [31:0]   ROW_INC = 32'(IMG_W);

  // Per-pixel attributes; hs/vs are "sync asserted" (active-high internally).
  typedef struct packed {
    logic vis;
    logic img;
    logic hs;
    logic vs;
    logic fs;
  } flags_t;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [31:0]   row_base_q, row_base_d;
  logic [31:0]   addr_d;
  flags_t        f0;
  flags_t [1:0]  pipe_q;  // [0]: address stage, [1]: data stage

  // Stage 0: raster counters and row base (BASE_ADDR + v*IMG_W, no multiplier)
  always_comb begin
    h_d        = h_q + 1'b1;
    v_d        = v_q;
    row_base_d = row_base_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      if (v_q == V_LAST) begin
        v_d        = '0;
        row_base_d = BASE_ADDR;
      end else begin
        v_d = v_q + 1'b1;
        if (v_q < V_IMG) row_base_d = row_base_q + ROW_INC;
      end
    end
  end

  always_comb begin
    f0     = '0;
    f0.vis = (h_q < H_VIS) && (v_q < V_VIS);
    f0.img = (h_q < H_IMG) && (v_q < V_IMG);
    f0.hs  = (h_q >= H_SS) && (h_q < H_SE);
    f0.vs  = (v_q >= V_SS) && (v_q < V_SE);
    f0.fs  = (h_q == '0) && (v_q == '0);
    addr_d = f0.img ? (row_base_q + 32'(h_q)) : BASE_ADDR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q         <= '0;
      v_q         <= '0;
      row_base_q  <= BASE_ADDR;
      gpu_address <= BASE_ADDR;
      pipe_q      <= '0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      row_base_q  <= row_base_d;
      gpu_address <= addr_d;
      pipe_q      <= {pipe_q[0], f0};
    end
  end

  // Output stage: vram_out is valid now for the pixel in the data stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      frame_start <= 1'b0;
    end else begin
      vga_hsync   <= ~pipe_q[1].hs;
      vga_vsync   <= ~pipe_q[1].vs;
      vga_blank_n <= pipe_q[1].vis;
      vga_r       <= pipe_q[1].img ? vram_out : 8'd0;
      vga_g       <= pipe_q[1].img ? vram_out : 8'd0;
      vga_b       <= pipe_q[1].img ? vram_out : 8'd0;
      frame_start <= pipe_q[1].fs;
    end
  end

endmodule
